// File: rtl/trap_ctrl.sv
// Trap entry/return sequencer between commit/LSU status, the machine-mode CSR write port and the IFU redirect.
// Optional build macro TRAP_CTRL_VECTORED_EN: vectored interrupt targets when mtvec.MODE == 2'b01.
module trap_ctrl #(
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_exc_valid,
  input  logic [4:0]  i_exc_cause,
  input  logic [31:0] i_exc_pc,
  input  logic        i_mret_valid,
  input  logic        i_commit_valid,
  input  logic [31:0] i_commit_npc,
  input  logic        i_irq_timer,
  input  logic        i_irq_ext,
  input  logic        i_mie,
  input  logic        i_lsu_busy,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  output logic        o_stall,
  output logic        o_csr_valid,
  output logic        o_csr_exception,
  output logic        o_csr_mret,
  output logic [31:0] o_csr_mcause,
  output logic [31:0] o_csr_epc,
  output logic        o_redirect_valid,
  input  logic        i_redirect_ready,
  output logic [31:0] o_redirect_pc,
  output logic        o_hang
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_UPDATE, S_REDIRECT} state_t;
  typedef enum logic [1:0] {K_NONE, K_EXC, K_MRET, K_IRQ} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] target_q, target_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hang_q, hang_d;
  logic [31:0] mtvec_base;
  logic [31:0] trap_target;

  assign mtvec_base = {i_mtvec[31:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
  // Only interrupts are vectored; synchronous exceptions always land on the base.
  assign trap_target = ((kind_q == K_IRQ) && (i_mtvec[1:0] == 2'b01))
                     ? mtvec_base + {25'd0, cause_q[4:0], 2'b00}
                     : mtvec_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^i_mtvec[1:0];
  assign trap_target       = mtvec_base;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      kind_q   <= K_NONE;
      cause_q  <= '0;
      epc_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      hang_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      hang_q   <= hang_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    hang_d   = hang_q;
    case (state_q)
      S_IDLE: begin
        if (i_exc_valid) begin
          kind_d  = K_EXC;
          cause_d = {27'd0, i_exc_cause};
          epc_d   = i_exc_pc;
          state_d = S_DRAIN;
        end else if (i_mret_valid) begin
          kind_d  = K_MRET;
          cause_d = '0;
          epc_d   = '0;
          state_d = S_DRAIN;
        end else if (i_commit_valid && i_mie && (i_irq_ext || i_irq_timer)) begin
          kind_d  = K_IRQ;
          cause_d = i_irq_ext ? 32'h8000_000B : 32'h8000_0007;
          epc_d   = i_commit_npc;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!i_lsu_busy) begin
          cnt_d   = '0;
          state_d = S_UPDATE;
        end else begin
          // Saturate so a long stall never wraps back below the timeout.
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_CNT) hang_d = 1'b1;
        end
      end
      S_UPDATE: begin
        target_d = (kind_q == K_MRET) ? i_mepc : trap_target;
        state_d  = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (i_redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic in_update, trap_update;
  assign in_update   = (state_q == S_UPDATE);
  assign trap_update = in_update && (kind_q != K_MRET);

  assign o_stall          = (state_q != S_IDLE);
  assign o_csr_valid      = in_update;
  assign o_csr_exception  = trap_update;
  assign o_csr_mret       = in_update && (kind_q == K_MRET);
  assign o_csr_mcause     = trap_update ? cause_q : 32'd0;
  assign o_csr_epc        = trap_update ? epc_q : 32'd0;
  assign o_redirect_valid = (state_q == S_REDIRECT);
  assign o_redirect_pc    = (state_q == S_REDIRECT) ? target_q : 32'd0;
  assign o_hang           = hang_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl: exception, mret, interrupt, drain timeout and async reset.
`timescale 1ns/1ps
module tb_trap_ctrl;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_exc_valid = 1'b0;
  logic [4:0]  i_exc_cause = '0;
  logic [31:0] i_exc_pc = '0;
  logic        i_mret_valid = 1'b0;
  logic        i_commit_valid = 1'b0;
  logic [31:0] i_commit_npc = '0;
  logic        i_irq_timer = 1'b0;
  logic        i_irq_ext = 1'b0;
  logic        i_mie = 1'b0;
  logic        i_lsu_busy = 1'b0;
  logic [31:0] i_mtvec = '0;
  logic [31:0] i_mepc = '0;
  logic        i_redirect_ready = 1'b0;
  logic        o_stall, o_csr_valid, o_csr_exception, o_csr_mret;
  logic [31:0] o_csr_mcause, o_csr_epc, o_redirect_pc;
  logic        o_redirect_valid, o_hang;

  int n_checks = 0;
  int n_fail   = 0;
  int mret_pulses;
  int strobes;

  trap_ctrl #(.DRAIN_TIMEOUT(255)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_exc_valid(i_exc_valid), .i_exc_cause(i_exc_cause), .i_exc_pc(i_exc_pc),
    .i_mret_valid(i_mret_valid), .i_commit_valid(i_commit_valid), .i_commit_npc(i_commit_npc),
    .i_irq_timer(i_irq_timer), .i_irq_ext(i_irq_ext), .i_mie(i_mie),
    .i_lsu_busy(i_lsu_busy), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
    .o_stall(o_stall), .o_csr_valid(o_csr_valid), .o_csr_exception(o_csr_exception),
    .o_csr_mret(o_csr_mret), .o_csr_mcause(o_csr_mcause), .o_csr_epc(o_csr_epc),
    .o_redirect_valid(o_redirect_valid), .i_redirect_ready(i_redirect_ready),
    .o_redirect_pc(o_redirect_pc), .o_hang(o_hang)
  );

  always #5 i_clock = ~i_clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic clear_req();
    i_exc_valid    = 1'b0;
    i_mret_valid   = 1'b0;
    i_commit_valid = 1'b0;
    i_irq_timer    = 1'b0;
    i_irq_ext      = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check_val("rst_stall", {31'd0, o_stall}, 32'd0);
    check_val("rst_csr_valid", {31'd0, o_csr_valid}, 32'd0);
    check_val("rst_redir_valid", {31'd0, o_redirect_valid}, 32'd0);
    check_val("rst_hang", {31'd0, o_hang}, 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
    i_mtvec = 32'h8000_1000;
    tick();

    // Synchronous exception, LSU idle
    i_exc_valid = 1'b1; i_exc_cause = 5'd11; i_exc_pc = 32'h8000_0100;
    tick();
    clear_req();
    check_val("exc_drain_stall", {31'd0, o_stall}, 32'd1);
    check_val("exc_drain_csr", {31'd0, o_csr_valid}, 32'd0);
    tick();
    check_val("exc_upd_valid", {31'd0, o_csr_valid}, 32'd1);
    check_val("exc_upd_exc", {31'd0, o_csr_exception}, 32'd1);
    check_val("exc_upd_mret", {31'd0, o_csr_mret}, 32'd0);
    check_val("exc_mcause", o_csr_mcause, 32'h0000_000B);
    check_val("exc_epc", o_csr_epc, 32'h8000_0100);
    check_val("exc_upd_redir", {31'd0, o_redirect_valid}, 32'd0);
    i_redirect_ready = 1'b1;
    tick();
    check_val("exc_redir_valid", {31'd0, o_redirect_valid}, 32'd1);
    check_val("exc_redir_pc", o_redirect_pc, 32'h8000_1000);
    check_val("exc_redir_csr", {31'd0, o_csr_valid}, 32'd0);
    tick();
    check_val("exc_idle_stall", {31'd0, o_stall}, 32'd0);
    check_val("exc_idle_redir", {31'd0, o_redirect_valid}, 32'd0);

    // mret with redirect back-pressure
    i_redirect_ready = 1'b0;
    i_mepc = 32'h8000_0104;
    i_mret_valid = 1'b1;
    mret_pulses = 0;
    tick();
    clear_req();
    mret_pulses += int'(o_csr_mret);
    tick();
    mret_pulses += int'(o_csr_mret);
    check_val("mret_upd_exc", {31'd0, o_csr_exception}, 32'd0);
    check_val("mret_mcause", o_csr_mcause, 32'd0);
    check_val("mret_epc", o_csr_epc, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      mret_pulses += int'(o_csr_mret);
      check_val($sformatf("mret_redir_valid_%0d", i), {31'd0, o_redirect_valid}, 32'd1);
      check_val($sformatf("mret_redir_pc_%0d", i), o_redirect_pc, 32'h8000_0104);
      if (i == 4) i_redirect_ready = 1'b1;
      tick();
    end
    mret_pulses += int'(o_csr_mret);
    check_val("mret_idle_stall", {31'd0, o_stall}, 32'd0);
    check_val("mret_idle_redir", {31'd0, o_redirect_valid}, 32'd0);
    check_val("mret_pulse_count", mret_pulses, 32'd1);

    // Interrupt at commit boundary, external beats timer
    i_commit_valid = 1'b1; i_commit_npc = 32'h8000_0200; i_mie = 1'b1;
    i_irq_timer = 1'b1; i_irq_ext = 1'b1;
    tick();
    clear_req();
    tick();
    check_val("irq_upd_exc", {31'd0, o_csr_exception}, 32'd1);
    check_val("irq_mcause", o_csr_mcause, 32'h8000_000B);
    check_val("irq_epc", o_csr_epc, 32'h8000_0200);
    tick();
    check_val("irq_redir_pc", o_redirect_pc, 32'h8000_1000);
    tick();

    // Interrupts masked: no capture
    i_mie = 1'b0; i_commit_valid = 1'b1; i_irq_timer = 1'b1; i_irq_ext = 1'b1;
    tick();
    check_val("irq_masked_stall0", {31'd0, o_stall}, 32'd0);
    tick();
    check_val("irq_masked_stall1", {31'd0, o_stall}, 32'd0);
    clear_req();

    // Exception beats mret; LSU busy long enough to trip the hang flag
    i_exc_valid = 1'b1; i_exc_cause = 5'd2; i_exc_pc = 32'h8000_0300;
    i_mret_valid = 1'b1; i_lsu_busy = 1'b1;
    tick();
    clear_req();
    for (int i = 1; i < 255; i++) tick();
    check_val("hang_before_timeout", {31'd0, o_hang}, 32'd0);
    tick();
    check_val("hang_at_timeout", {31'd0, o_hang}, 32'd1);
    for (int i = 0; i < 45; i++) tick();
    check_val("hang_sticky", {31'd0, o_hang}, 32'd1);
    check_val("hang_still_drain", {31'd0, o_csr_valid}, 32'd0);
    check_val("hang_still_stall", {31'd0, o_stall}, 32'd1);
    i_lsu_busy = 1'b0;
    tick();
    check_val("prio_upd_exc", {31'd0, o_csr_exception}, 32'd1);
    check_val("prio_upd_mret", {31'd0, o_csr_mret}, 32'd0);
    check_val("prio_mcause", o_csr_mcause, 32'h0000_0002);
    check_val("prio_epc", o_csr_epc, 32'h8000_0300);
    tick();
    tick();
    check_val("hang_after_idle", {31'd0, o_hang}, 32'd1);

    // Async reset while holding a redirect
    i_redirect_ready = 1'b0;
    i_exc_valid = 1'b1; i_exc_cause = 5'd4; i_exc_pc = 32'h8000_0400;
    tick();
    clear_req();
    tick();
    tick();
    check_val("arst_pre_redir", {31'd0, o_redirect_valid}, 32'd1);
    #2 i_reset = 1'b0;
    #1;
    check_val("arst_redir_valid", {31'd0, o_redirect_valid}, 32'd0);
    check_val("arst_redir_pc", o_redirect_pc, 32'd0);
    check_val("arst_stall", {31'd0, o_stall}, 32'd0);
    check_val("arst_hang", {31'd0, o_hang}, 32'd0);
    check_val("arst_csr_valid", {31'd0, o_csr_valid}, 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
    i_redirect_ready = 1'b1;
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      strobes += int'(o_csr_valid);
    end
    check_val("arst_no_strobe", strobes, 32'd0);

    // Timer interrupt with mtvec in vectored mode
    i_mtvec = 32'h8000_1001;
    i_mie = 1'b1; i_commit_valid = 1'b1; i_commit_npc = 32'h8000_0500; i_irq_timer = 1'b1;
    tick();
    clear_req();
    tick();
    check_val("vec_mcause", o_csr_mcause, 32'h8000_0007);
    tick();
`ifdef TRAP_CTRL_VECTORED_EN
    check_val("vec_redir_pc", o_redirect_pc, 32'h8000_101C);
`else
    check_val("vec_redir_pc", o_redirect_pc, 32'h8000_1000);
`endif
    tick();
    check_val("vec_idle_stall", {31'd0, o_stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences trap entry and return around the machine-mode CSR file; sits between commit/LSU status and the CSR write port and IFU redirect.
- Captures one event at a time: synchronous exception, mret, or interrupt at an instruction boundary.
- Stalls the pipeline, waits for LSU drain, issues a one-cycle CSR update, then holds a valid/ready redirect to the IFU.

Parameters:
- DRAIN_TIMEOUT, 255, cycles in DRAIN before o_hang asserts; 8-bit counter width.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  reset, asynchronous, active-low
- i_exc_valid  in  1  committing instruction raised exception
- i_exc_cause  in  5  exception cause code
- i_exc_pc  in  32  PC of faulting instruction
- i_mret_valid  in  1  committing instruction is mret
- i_commit_valid  in  1  instruction retired this cycle (interrupt boundary)
- i_commit_npc  in  32  next PC after retired instruction
- i_irq_timer  in  1  timer interrupt pending, level
- i_irq_ext  in  1  external interrupt pending, level
- i_mie  in  1  mstatus.MIE from CSR file
- i_lsu_busy  in  1  outstanding memory transaction
- i_mtvec  in  32  current mtvec
- i_mepc  in  32  current mepc
- o_stall  out  1  freeze fetch/commit
- o_csr_valid  out  1  CSR update strobe
- o_csr_exception  out  1  write mcause/mepc
- o_csr_mret  out  1  mret return
- o_csr_mcause  out  32  cause to write
- o_csr_epc  out  32  epc to write
- o_redirect_valid  out  1  redirect request
- i_redirect_ready  in  1  IFU accepts redirect
- o_redirect_pc  out  32  redirect target
- o_hang  out  1  sticky drain-timeout flag

Behaviour:
- States: IDLE, DRAIN, UPDATE, REDIRECT.
- Reset (i_reset low, any time, async):
  - state=IDLE; all outputs 0; kind/cause/epc/counter cleared.
  - Reset mid-operation abandons the event with no CSR write.
- IDLE capture priority (same cycle):
  1. i_exc_valid -> kind=EXC, cause={27'b0,i_exc_cause}, epc=i_exc_pc.
  2. else i_mret_valid -> kind=MRET.
  3. else i_commit_valid & i_mie & (i_irq_ext|i_irq_timer) -> kind=IRQ, epc=i_commit_npc, cause=0x8000000B if ext (ext beats timer), else 0x80000007.
  - On capture -> DRAIN. No capture -> stay in IDLE.
- o_stall = (state != IDLE), registered. All request inputs are ignored outside IDLE.
- DRAIN:
  - Counter increments each cycle.
  - Leave when i_lsu_busy=0, checked in the same cycle as DRAIN is entered + 1; minimum 1 cycle in DRAIN -> UPDATE.
  - Counter reaching DRAIN_TIMEOUT sets o_hang, sticky until reset. FSM keeps waiting.
  - Counter clears on leaving DRAIN.
- UPDATE, exactly 1 cycle:
  - o_csr_valid=1.
  - EXC/IRQ: o_csr_exception=1, mcause/epc driven.
  - MRET: o_csr_mret=1, mcause/epc=0.
  - Target latched this cycle: EXC/IRQ -> {i_mtvec[31:2],2'b00}; MRET -> i_mepc.
  - -> REDIRECT.
- REDIRECT:
  - o_redirect_valid=1 with stable o_redirect_pc.
  - Transfer on valid&ready -> IDLE next cycle.
  - ready already high on entry -> 1-cycle REDIRECT.
- Latency, capture to redirect valid: 3 cycles minimum.
- o_csr_* are 0 outside UPDATE. o_redirect_* are 0 outside REDIRECT.

Optional Feature:
- TRAP_CTRL_VECTORED_EN defined, i_mtvec[1:0]==2'b01, kind=IRQ:
  - target = {i_mtvec[31:2],2'b00} + 4*cause[4:0].
  - EXC/MRET targets unchanged.
- Undefined: all traps use direct base, mtvec[1:0] ignored.

Test Plan:
- exc_valid, cause=11, pc=0x80000100, mtvec=0x80001000, lsu idle -> UPDATE: mcause=0x0000000B, epc=0x80000100; redirect 0x80001000 three cycles after capture.
- mret_valid, mepc=0x80000104, ready held low 4 cycles -> valid and pc stable 4 cycles; IDLE one cycle after ready; o_csr_mret pulses once.
- commit_valid, npc=0x80000200, mie=1, timer=1, ext=1 -> cause=0x8000000B, epc=0x80000200. Repeat with mie=0 -> no capture, o_stall stays 0.
- exc_valid and mret_valid same cycle -> EXC taken. lsu_busy held 300 cycles -> o_hang rises at 255 and stays; UPDATE follows busy drop.
- Async reset asserted in REDIRECT -> all outputs 0 immediately, no further CSR strobe after release.
- TRAP_CTRL_VECTORED_EN, mtvec=0x80001001, timer IRQ -> redirect 0x8000101C. Without macro -> 0x80001000.
